// File: rtl/mux_n_to_1_pipe.sv
// Registered N:1 word selector with valid/ready handshake and a skid register.
// Out-of-range selects fall back to DEFAULT_IDX, are flagged per beat and counted.
module mux_n_to_1_pipe #(
    parameter int WIDTH       = 32,
    parameter int NUM_IN      = 3,
    parameter int SEL_W       = 2,
    parameter int DEFAULT_IDX = 0,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_oob,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    clr_err,
    output logic                    sticky_err,
    output logic [CNT_W-1:0]        err_count
);

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_oob;
    logic [WIDTH-1:0] sel_word;
    logic             sel_oob;
    logic             accept;
    logic             advance;

    // Only the skid flag gates in_ready, so out_ready never reaches upstream.
    assign in_ready = !rst && !skid_valid;
    assign accept   = in_valid && in_ready;
    assign advance  = !out_valid || out_ready;

    always_comb begin
        sel_word = in_data[DEFAULT_IDX*WIDTH +: WIDTH];
        sel_oob  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_word = in_data[k*WIDTH +: WIDTH];
                sel_oob  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_oob    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_oob   <= 1'b0;
            sticky_err <= 1'b0;
            err_count  <= '0;
        end else begin
            if (advance) begin
                // Skid beat is older than anything arriving now, so it drains first.
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    out_oob    <= skid_oob;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    out_valid <= 1'b1;
                    out_data  <= sel_word;
                    out_oob   <= sel_oob;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_data  <= sel_word;
                skid_oob   <= sel_oob;
            end

            if (clr_err) begin
                sticky_err <= 1'b0;
                err_count  <= '0;
            end else if (accept && sel_oob) begin
                sticky_err <= 1'b1;
                if (err_count != '1)
                    err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_to_1_pipe.sv
// Directed checks of mux_n_to_1_pipe (3 inputs, 2-bit error counter) followed
// by a randomized stretch checked against a small occupancy/queue model.
module tb_mux_n_to_1_pipe;

    localparam int WIDTH = 8;
    localparam int NUM_IN = 3;
    localparam int SEL_W = 2;
    localparam int CNT_W = 2;

    logic                    clk;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_oob;
    logic                    out_valid;
    logic                    out_ready;
    logic                    clr_err;
    logic                    sticky_err;
    logic [CNT_W-1:0]        err_count;

    int total = 0;
    int bad = 0;

    mux_n_to_1_pipe #(
        .WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W), .DEFAULT_IDX(0), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_oob(out_oob), .out_valid(out_valid), .out_ready(out_ready),
        .clr_err(clr_err), .sticky_err(sticky_err), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        logic [WIDTH:0] q[$];
        logic [WIDTH:0] head;
        int occ;
        int ecnt;
        int s;
        logic acc;
        logic fire;
        logic [WIDTH-1:0] w;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
        in_data = {8'h33, 8'h22, 8'h11}; in_sel = '0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_sticky", 32'(sticky_err), 0);
        rst = 1'b0; #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // streaming 0,1,2
        in_valid = 1'b1; in_sel = 2'd0; tick();
        chk("st0_data", 32'(out_data), 32'h11);
        chk("st0_valid", 32'(out_valid), 1);
        chk("st0_oob", 32'(out_oob), 0);
        in_sel = 2'd1; tick();
        chk("st1_data", 32'(out_data), 32'h22);
        chk("st1_valid", 32'(out_valid), 1);
        in_sel = 2'd2; tick();
        chk("st2_data", 32'(out_data), 32'h33);
        chk("st2_valid", 32'(out_valid), 1);
        chk("st2_oob", 32'(out_oob), 0);
        in_valid = 1'b0; tick();
        chk("st_drain_valid", 32'(out_valid), 0);

        // out-of-range select
        in_valid = 1'b1; in_sel = 2'd3; tick();
        in_valid = 1'b0;
        chk("oob_data", 32'(out_data), 32'h11);
        chk("oob_flag", 32'(out_oob), 1);
        chk("oob_sticky", 32'(sticky_err), 1);
        chk("oob_count", 32'(err_count), 1);
        tick();
        chk("oob_drain_valid", 32'(out_valid), 0);

        // back-pressure fill and release
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0; tick();
        chk("bp_out0", 32'(out_data), 32'h11);
        chk("bp_ready0", 32'(in_ready), 1);
        in_sel = 2'd1; tick();
        chk("bp_hold0", 32'(out_data), 32'h11);
        chk("bp_ready1", 32'(in_ready), 0);
        in_sel = 2'd2; tick();
        chk("bp_hold1", 32'(out_data), 32'h11);
        chk("bp_ready2", 32'(in_ready), 0);
        chk("bp_valid", 32'(out_valid), 1);
        out_ready = 1'b1; tick();
        chk("bp_rel_out1", 32'(out_data), 32'h22);
        chk("bp_rel_ready", 32'(in_ready), 1);
        tick();
        chk("bp_rel_out2", 32'(out_data), 32'h33);
        chk("bp_rel_valid", 32'(out_valid), 1);
        in_valid = 1'b0; tick();
        chk("bp_empty", 32'(out_valid), 0);

        // clear, then saturate the 2-bit counter
        clr_err = 1'b1; tick();
        clr_err = 1'b0;
        chk("clr_count", 32'(err_count), 0);
        chk("clr_sticky", 32'(sticky_err), 0);
        in_valid = 1'b1; in_sel = 2'd3;
        tick(); tick();
        chk("sat_count2", 32'(err_count), 2);
        tick(); tick(); tick();
        chk("sat_count5", 32'(err_count), 3);
        chk("sat_sticky", 32'(sticky_err), 1);
        clr_err = 1'b1; tick();
        clr_err = 1'b0; in_valid = 1'b0;
        chk("clr_prio_count", 32'(err_count), 0);
        chk("clr_prio_sticky", 32'(sticky_err), 0);
        tick();

        // fill both entries, offer a refused oob beat, then reset mid-stall
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0; tick();
        in_sel = 2'd1; tick();
        in_sel = 2'd3; tick();
        chk("refused_oob_count", 32'(err_count), 0);
        chk("refused_oob_sticky", 32'(sticky_err), 0);
        chk("stall_out", 32'(out_data), 32'h11);
        in_valid = 1'b0; rst = 1'b1; tick();
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_count", 32'(err_count), 0);
        rst = 1'b0; out_ready = 1'b1; #1;
        chk("mid_rst_ready_back", 32'(in_ready), 1);
        tick();
        chk("mid_rst_no_replay", 32'(out_valid), 0);

        // randomized traffic against a queue model
        occ = 0; ecnt = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            chk("rnd_valid", 32'(out_valid), 32'(occ > 0));
            chk("rnd_in_ready", 32'(in_ready), 32'(occ < 2));
            chk("rnd_count", 32'(err_count), 32'(ecnt));
            if (occ > 0) begin
                head = q[0];
                chk("rnd_data", 32'(out_data), 32'(head[WIDTH-1:0]));
                chk("rnd_oob", 32'(out_oob), 32'(head[WIDTH]));
            end
            if (!(in_valid && occ >= 2)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_sel = SEL_W'($urandom_range(0, 3));
                in_data = 24'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            acc = in_valid && (occ < 2);
            fire = (occ > 0) && out_ready;
            if (fire) begin
                void'(q.pop_front());
                occ--;
            end
            if (acc) begin
                s = int'(in_sel);
                w = (s < NUM_IN) ? in_data[s*WIDTH +: WIDTH] : in_data[WIDTH-1:0];
                q.push_back({1'(s >= NUM_IN), w});
                occ++;
                if (s >= NUM_IN && ecnt < 3) ecnt++;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
